accum_history: RTL and testbench

- Parametrised successor to the 16-bit update/hold accumulator register.
- Holds the current accumulator value plus a bounded history of previous values, so the user can undo the last DEPTH updates.
- Sits between the ALU result bus and the display/operand path of the calculator datapath.
- Update and undo are driven by debounced push-buttons. An optional edge-detect mode makes a held button act exactly once.

---
 rtl/accum_history.sv | 107 ++++++++++
 tb/tb_accum_history.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/accum_history.sv
// rtl/accum_history.sv - accumulator register with bounded undo history
module accum_history #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 3,
  parameter int EDGE_MODE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             update,
  input  logic             undo,
  input  logic [WIDTH-1:0] r_in,
  output logic [WIDTH-1:0] r_out,
  output logic [CNT_W-1:0] hist_cnt,
  output logic             can_undo,
  output logic             hist_full,
  output logic             dropped,
  output logic             undo_err
);

  // Pointer only needs to address DEPTH entries; DEPTH >= 2 keeps PW >= 1.
  localparam int PW = $clog2(DEPTH);

  localparam logic [PW-1:0]    WP_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0]    WP_ONE  = PW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    tp;
  logic             update_prev;
  logic             undo_prev;
  logic             upd_q;
  logic             und_q;
  logic             do_push;

  // Qualify the buttons: rising edge only, or plain level when edge mode is off.
  always_comb begin
    upd_q = update;
    und_q = undo;
    if (EDGE_MODE != 0) begin
      upd_q = update & ~update_prev;
      und_q = undo & ~undo_prev;
    end
  end

  // Slot of the most recent history entry, wrapping 0 -> DEPTH-1.
  always_comb begin
    tp = (wp == '0) ? WP_LAST : (wp - WP_ONE);
  end

  // Clear outranks update, so a push only happens when clear is low.
  assign do_push   = ~clear & upd_q;
  assign can_undo  = (hist_cnt != '0);
  assign hist_full = (hist_cnt == CNT_MAX);

  // History storage: plain register array, contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wp] <= r_out;
    end
  end

  // Accumulator, pointer, count and flag pulses; clear > update > undo.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out       <= '0;
      hist_cnt    <= '0;
      wp          <= '0;
      dropped     <= 1'b0;
      undo_err    <= 1'b0;
      // Held-high buttons must not look like a fresh press after reset.
      update_prev <= 1'b1;
      undo_prev   <= 1'b1;
    end else begin
      update_prev <= update;
      undo_prev   <= undo;
      dropped     <= 1'b0;
      undo_err    <= 1'b0;
      if (clear) begin
        r_out    <= '0;
        hist_cnt <= '0;
        wp       <= '0;
      end else if (upd_q) begin
        r_out <= r_in;
        wp    <= (wp == WP_LAST) ? '0 : (wp + WP_ONE);
        if (hist_cnt < CNT_MAX) begin
          hist_cnt <= hist_cnt + CNT_ONE;
        end else begin
          // Circular write has just replaced the oldest entry.
          dropped <= 1'b1;
        end
      end else if (und_q) begin
        if (hist_cnt != '0) begin
          r_out    <= mem[tp];
          wp       <= tp;
          hist_cnt <= hist_cnt - CNT_ONE;
        end else begin
          undo_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_accum_history.sv
// tb/tb_accum_history.sv - directed checks for accum_history in edge and level modes
module tb_accum_history;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        update;
  logic        undo;
  logic [15:0] r_in;

  logic [15:0] e_r_out;
  logic [2:0]  e_hist_cnt;
  logic        e_can_undo;
  logic        e_hist_full;
  logic        e_dropped;
  logic        e_undo_err;

  logic [15:0] l_r_out;
  logic [2:0]  l_hist_cnt;
  logic        l_can_undo;
  logic        l_hist_full;
  logic        l_dropped;
  logic        l_undo_err;

  int checks;
  int errors;
  logic last_dropped;
  logic last_undo_err;

  accum_history #(.WIDTH(16), .DEPTH(4), .CNT_W(3), .EDGE_MODE(1)) u_edge (
    .clk(clk), .reset(reset), .clear(clear), .update(update), .undo(undo),
    .r_in(r_in), .r_out(e_r_out), .hist_cnt(e_hist_cnt), .can_undo(e_can_undo),
    .hist_full(e_hist_full), .dropped(e_dropped), .undo_err(e_undo_err)
  );

  accum_history #(.WIDTH(16), .DEPTH(4), .CNT_W(3), .EDGE_MODE(0)) u_lvl (
    .clk(clk), .reset(reset), .clear(clear), .update(update), .undo(undo),
    .r_in(r_in), .r_out(l_r_out), .hist_cnt(l_hist_cnt), .can_undo(l_can_undo),
    .hist_full(l_hist_full), .dropped(l_dropped), .undo_err(l_undo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press_upd(input logic [15:0] v);
    r_in = v;
    update = 1'b1;
    tick();
    last_dropped = e_dropped;
    update = 1'b0;
    tick();
  endtask

  task automatic press_undo();
    undo = 1'b1;
    tick();
    last_undo_err = e_undo_err;
    undo = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    clear = 1'b0;
    update = 1'b0;
    undo = 1'b0;
    r_in = 16'h0000;
    last_dropped = 1'b0;
    last_undo_err = 1'b0;

    #12;
    chk("reset_r_out", e_r_out, 16'h0000);
    chk("reset_hist_cnt", e_hist_cnt, 3'd0);
    chk("reset_can_undo", e_can_undo, 1'b0);
    chk("reset_hist_full", e_hist_full, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("idle_r_out", e_r_out, 16'h0000);

    // Three pushes then unwind them.
    press_upd(16'h0011);
    press_upd(16'h0022);
    press_upd(16'h0033);
    chk("upd3_r_out", e_r_out, 16'h0033);
    chk("upd3_hist_cnt", e_hist_cnt, 3'd3);
    chk("upd3_can_undo", e_can_undo, 1'b1);
    press_undo();
    chk("undo1_r_out", e_r_out, 16'h0022);
    press_undo();
    chk("undo2_r_out", e_r_out, 16'h0011);
    press_undo();
    chk("undo3_r_out", e_r_out, 16'h0000);
    chk("undo3_hist_cnt", e_hist_cnt, 3'd0);
    undo = 1'b1;
    tick();
    chk("undo_empty_err", e_undo_err, 1'b1);
    chk("undo_empty_r_out", e_r_out, 16'h0000);
    undo = 1'b0;
    tick();
    chk("undo_err_clears", e_undo_err, 1'b0);

    // Overflow the history and check the oldest entries are lost.
    for (int i = 1; i <= 6; i++) begin
      press_upd(16'(i));
      if (i == 4) chk("full_after_4", e_hist_full, 1'b1);
      if (i == 5) chk("dropped_5", last_dropped, 1'b1);
      if (i == 6) chk("dropped_6", last_dropped, 1'b1);
      if (i == 3) chk("not_full_3", e_hist_full, 1'b0);
      if (i == 4) chk("no_drop_4", last_dropped, 1'b0);
    end
    chk("dropped_clears", e_dropped, 1'b0);
    chk("ovf_r_out", e_r_out, 16'h0006);
    chk("ovf_hist_cnt", e_hist_cnt, 3'd4);
    press_undo();
    chk("ovf_undo1", e_r_out, 16'h0005);
    press_undo();
    chk("ovf_undo2", e_r_out, 16'h0004);
    press_undo();
    chk("ovf_undo3", e_r_out, 16'h0003);
    press_undo();
    chk("ovf_undo4", e_r_out, 16'h0002);
    chk("ovf_undo4_cnt", e_hist_cnt, 3'd0);
    press_undo();
    chk("ovf_undo5_err", last_undo_err, 1'b1);
    chk("ovf_undo5_r_out", e_r_out, 16'h0002);

    // Held update: edge mode pushes once, level mode pushes every cycle.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    chk("clr_edge_cnt", e_hist_cnt, 3'd0);
    chk("clr_lvl_cnt", l_hist_cnt, 3'd0);
    chk("clr_lvl_r_out", l_r_out, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      r_in = 16'h0100 + 16'(i);
      update = 1'b1;
      tick();
      chk($sformatf("lvl_cnt_%0d", i), l_hist_cnt, (i < 4) ? 32'(i + 1) : 32'd4);
      chk($sformatf("lvl_drop_%0d", i), l_dropped, (i >= 4) ? 1'b1 : 1'b0);
    end
    update = 1'b0;
    tick();
    chk("hold_edge_r_out", e_r_out, 16'h0100);
    chk("hold_edge_cnt", e_hist_cnt, 3'd1);
    chk("hold_lvl_r_out", l_r_out, 16'h0109);
    chk("hold_lvl_cnt", l_hist_cnt, 3'd4);

    // Priority: clear beats everything, update beats undo.
    press_upd(16'h1234);
    chk("pri_pre_r_out", e_r_out, 16'h1234);
    clear = 1'b1;
    update = 1'b1;
    undo = 1'b1;
    r_in = 16'h5555;
    tick();
    chk("pri_clear_r_out", e_r_out, 16'h0000);
    chk("pri_clear_cnt", e_hist_cnt, 3'd0);
    clear = 1'b0;
    update = 1'b0;
    undo = 1'b0;
    tick();
    update = 1'b1;
    undo = 1'b1;
    r_in = 16'h0077;
    tick();
    chk("pri_upd_r_out", e_r_out, 16'h0077);
    chk("pri_upd_cnt", e_hist_cnt, 3'd1);
    chk("pri_upd_no_err", e_undo_err, 1'b0);
    undo = 1'b0;

    // Asynchronous reset mid-stream with update held across release.
    reset = 1'b1;
    #2;
    chk("async_r_out", e_r_out, 16'h0000);
    chk("async_cnt", e_hist_cnt, 3'd0);
    chk("async_can_undo", e_can_undo, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("held_no_push_cnt", e_hist_cnt, 3'd0);
    chk("held_no_push_r_out", e_r_out, 16'h0000);
    update = 1'b0;
    tick();
    press_upd(16'h0099);
    chk("after_release_r_out", e_r_out, 16'h0099);
    chk("after_release_cnt", e_hist_cnt, 3'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
